// File: rtl/elev_pkg.sv
// rtl/elev_pkg.sv - shared constants, state/direction enums and call-search helpers for the elevator scheduler
package elev_pkg;

  localparam int NUM_FLOORS = 4;
  localparam int FLOOR_W    = 2;

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  function automatic logic any_above(input logic [NUM_FLOORS-1:0] calls,
                                     input logic [FLOOR_W-1:0]    floor);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i > int'(floor) && calls[i]) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic any_below(input logic [NUM_FLOORS-1:0] calls,
                                     input logic [FLOOR_W-1:0]    floor);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i < int'(floor) && calls[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/elevator_scheduler_if.sv
// rtl/elevator_scheduler_if.sv - call/status bundle between the car controller and its environment
// estop is only present when ELEV_ESTOP_EN is defined.
interface elevator_scheduler_if;
  import elev_pkg::*;

  logic [NUM_FLOORS-1:0] req;
  logic [FLOOR_W-1:0]    floor_code;
  logic                  moving_up;
  logic                  moving_down;
  logic                  door_open;
  logic [NUM_FLOORS-1:0] pending;
`ifdef ELEV_ESTOP_EN
  logic                  estop;

  modport master (output req, output estop,
                  input floor_code, input moving_up, input moving_down,
                  input door_open, input pending);
  modport slave  (input req, input estop,
                  output floor_code, output moving_up, output moving_down,
                  output door_open, output pending);
`else
  modport master (output req,
                  input floor_code, input moving_up, input moving_down,
                  input door_open, input pending);
  modport slave  (input req,
                  output floor_code, output moving_up, output moving_down,
                  output door_open, output pending);
`endif

endinterface

// File: rtl/elev_tick_timer.sv
// rtl/elev_tick_timer.sv - cycle counter 0..TICKS-1 with restart, hold and a terminal-count pulse
module elev_tick_timer #(
  parameter int TICKS = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic hold,
  input  logic restart,
  output logic tc
);

  localparam int            CW   = $clog2(TICKS);
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

  logic [CW-1:0] cnt_q;

  // hold freezes everything, including a pending restart
  assign tc = en && !hold && !restart && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!hold) begin
      if (restart || tc) begin
        cnt_q <= '0;
      end else if (en) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/elevator_scheduler.sv
// rtl/elevator_scheduler.sv - 4-floor SCAN elevator sequencer with travel/door timing
// Define ELEV_ESTOP_EN to add the estop freeze input.
module elevator_scheduler
  import elev_pkg::*;
#(
  parameter int TRAVEL_TICKS = 8,
  parameter int DOOR_TICKS   = 5
) (
  input logic                 clk,
  input logic                 rst_n,
  elevator_scheduler_if.slave bus
);

  state_t                state_q, state_d;
  dir_t                  dir_q, dir_d;
  logic [FLOOR_W-1:0]    floor_q, floor_d;
  logic [NUM_FLOORS-1:0] pend_q, pend_d;
  logic                  up_q, down_q, door_q;

  logic                  frozen;
  logic [NUM_FLOORS-1:0] floor_bit;
  logic [NUM_FLOORS-1:0] pend_now;
  logic                  here_req;
  logic [FLOOR_W-1:0]    floor_step;
  logic [FLOOR_W-1:0]    dec_floor;
  logic                  calls_up, calls_down, ahead, behind;
  logic                  travel_tc, door_tc;

`ifdef ELEV_ESTOP_EN
  assign frozen = bus.estop;
`else
  assign frozen = 1'b0;
`endif

  // A call at the car's own floor is served in place while stopped, so it never latches.
  assign floor_bit = {{(NUM_FLOORS-1){1'b0}}, 1'b1} << floor_q;
  assign pend_now  = pend_q | (bus.req & ~((state_q != MOVE) ? floor_bit : '0));
  assign here_req  = bus.req[floor_q];

  assign floor_step = (dir_q == DIR_UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
  assign dec_floor  = (state_q == MOVE) ? floor_step : floor_q;
  assign calls_up   = any_above(pend_now, dec_floor);
  assign calls_down = any_below(pend_now, dec_floor);
  assign ahead      = (dir_q == DIR_UP) ? calls_up : calls_down;
  assign behind     = (dir_q == DIR_UP) ? calls_down : calls_up;

  elev_tick_timer #(.TICKS(TRAVEL_TICKS)) u_travel_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state_q == MOVE),
    .hold    (frozen),
    .restart (state_q != MOVE),
    .tc      (travel_tc)
  );

  elev_tick_timer #(.TICKS(DOOR_TICKS)) u_door_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state_q == DOOR),
    .hold    (frozen),
    .restart ((state_q == DOOR) && here_req),
    .tc      (door_tc)
  );

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    floor_d = floor_q;
    pend_d  = pend_now;
    if (!frozen) begin
      case (state_q)
        IDLE: begin
          if (here_req) begin
            state_d = DOOR;
          end else if (calls_up) begin
            state_d = MOVE;
            dir_d   = DIR_UP;
          end else if (calls_down) begin
            state_d = MOVE;
            dir_d   = DIR_DOWN;
          end
        end
        MOVE: begin
          if (travel_tc) begin
            floor_d = floor_step;
            // a call landing on the arrival edge is served by this stop
            if (pend_now[floor_step]) begin
              state_d             = DOOR;
              pend_d[floor_step]  = 1'b0;
            end else if (ahead) begin
              state_d = MOVE;
            end else if (behind) begin
              state_d = MOVE;
              dir_d   = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
            end else begin
              state_d = IDLE;
            end
          end
        end
        DOOR: begin
          if (door_tc) begin
            if (ahead) begin
              state_d = MOVE;
            end else if (behind) begin
              state_d = MOVE;
              dir_d   = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dir_q   <= DIR_UP;
      floor_q <= '0;
      pend_q  <= '0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      door_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      floor_q <= floor_d;
      pend_q  <= pend_d;
      up_q    <= !frozen && (state_d == MOVE) && (dir_d == DIR_UP);
      down_q  <= !frozen && (state_d == MOVE) && (dir_d == DIR_DOWN);
      door_q  <= (state_d == DOOR);
    end
  end

  assign bus.floor_code  = floor_q;
  assign bus.moving_up   = up_q;
  assign bus.moving_down = down_q;
  assign bus.door_open   = door_q;
  assign bus.pending     = pend_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// tb/tb_elevator_scheduler.sv - self-checking bench for elevator_scheduler against a call-list reference model
module tb_elevator_scheduler;

  localparam int TT = 8;
  localparam int DT = 5;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  elevator_scheduler_if bus();

  elevator_scheduler #(.TRAVEL_TICKS(TT), .DOOR_TICKS(DT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference car: 0 idle, 1 travelling, 2 door open; one timer since only one phase runs at a time.
  int       m_state;
  int       m_floor;
  bit       m_up;
  bit [3:0] m_pend;
  int       m_t;
  bit       m_mu, m_md, m_door;

  function automatic bit m_any(input bit [3:0] p, input int f, input bit up);
    for (int i = 0; i < 4; i++) begin
      if ((up ? (i > f) : (i < f)) && p[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_floor = 0; m_up = 1'b1; m_pend = '0; m_t = 0;
    m_mu = 1'b0; m_md = 1'b0; m_door = 1'b0;
  endtask

  task automatic m_choose(input bit [3:0] pn);
    if (m_any(pn, m_floor, m_up)) begin
      m_state = 1;
    end else if (m_any(pn, m_floor, !m_up)) begin
      m_state = 1;
      m_up    = !m_up;
    end else begin
      m_state = 0;
    end
  endtask

  task automatic model_step(input logic [3:0] r, input logic e);
    bit [3:0] pn;
    pn = m_pend | r;
    if (m_state != 1) pn[m_floor] = 1'b0;
    if (e) begin
      m_pend = pn;
      m_mu   = 1'b0;
      m_md   = 1'b0;
      return;
    end
    case (m_state)
      0: begin
        if (r[m_floor]) begin
          m_state = 2; m_t = 0;
        end else if (m_any(pn, m_floor, 1'b1)) begin
          m_state = 1; m_up = 1'b1; m_t = 0;
        end else if (m_any(pn, m_floor, 1'b0)) begin
          m_state = 1; m_up = 1'b0; m_t = 0;
        end
      end
      1: begin
        if (m_t == TT - 1) begin
          m_floor = m_floor + (m_up ? 1 : -1);
          m_t     = 0;
          if (pn[m_floor]) begin
            pn[m_floor] = 1'b0;
            m_state     = 2;
          end else begin
            m_choose(pn);
          end
        end else begin
          m_t++;
        end
      end
      default: begin
        if (r[m_floor]) begin
          m_t = 0;
        end else if (m_t == DT - 1) begin
          m_t = 0;
          m_choose(pn);
        end else begin
          m_t++;
        end
      end
    endcase
    m_pend = pn;
    m_mu   = (m_state == 1) && m_up;
    m_md   = (m_state == 1) && !m_up;
    m_door = (m_state == 2);
  endtask

  function automatic logic [8:0] obs_vec();
    return {bus.floor_code, bus.moving_up, bus.moving_down, bus.door_open, bus.pending};
  endfunction

  function automatic logic [8:0] exp_vec();
    return {2'(m_floor), m_mu, m_md, m_door, m_pend};
  endfunction

  task automatic tick(input logic [3:0] r, input logic e);
    bus.req = r;
`ifdef ELEV_ESTOP_EN
    bus.estop = e;
`endif
    @(posedge clk);
    model_step(r, e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.req = '0;
`ifdef ELEV_ESTOP_EN
    bus.estop = 1'b0;
`endif
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    bus.req = '0;
`ifdef ELEV_ESTOP_EN
    bus.estop = 1'b0;
`endif
    #1;
    checks++;
    if (obs_vec() !== 9'b0) begin
      errors++; $display("FAIL reset_asserted obs=%b required=%b", obs_vec(), 9'b0);
    end
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick(4'b0000, 1'b0);
      checks++;
      if (obs_vec() !== 9'b0) begin
        errors++; $display("FAIL reset_idle cyc=%0d obs=%b required=%b", k, obs_vec(), 9'b0);
      end
    end
  endtask

  task automatic test_single_up();
    int f1, f2, f3, dcnt;
    logic [1:0] last;
    do_reset();
    tick(4'b1000, 1'b0);
    checks++;
    if ({bus.moving_up, bus.moving_down} !== 2'b10) begin
      errors++; $display("FAIL up_entry moving=%b required=10", {bus.moving_up, bus.moving_down});
    end
    f1 = -1; f2 = -1; f3 = -1; dcnt = 0; last = bus.floor_code;
    for (int k = 1; k <= 40; k++) begin
      tick(4'b0000, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL up_model cyc=%0d obs=%b required=%b", k, obs_vec(), exp_vec());
      end
      if (bus.floor_code !== last) begin
        if (bus.floor_code == 2'd1) f1 = k;
        if (bus.floor_code == 2'd2) f2 = k;
        if (bus.floor_code == 2'd3) f3 = k;
        last = bus.floor_code;
      end
      if (bus.door_open) dcnt++;
    end
    checks++; if (f1 != TT)     begin errors++; $display("FAIL up_floor1_time got=%0d required=%0d", f1, TT); end
    checks++; if (f2 != 2 * TT) begin errors++; $display("FAIL up_floor2_time got=%0d required=%0d", f2, 2 * TT); end
    checks++; if (f3 != 3 * TT) begin errors++; $display("FAIL up_floor3_time got=%0d required=%0d", f3, 3 * TT); end
    checks++; if (dcnt != DT)   begin errors++; $display("FAIL up_door_cycles got=%0d required=%0d", dcnt, DT); end
    checks++;
    if (obs_vec() !== {2'd3, 7'b0}) begin
      errors++; $display("FAIL up_final obs=%b required=%b", obs_vec(), {2'd3, 7'b0});
    end
  endtask

  task automatic test_scan();
    int exp_seq[6] = '{1, 2, 3, 2, 1, 0};
    int seq[$];
    int doors[$];
    logic prev_door;
    do_reset();
    tick(4'b0010, 1'b0);
    for (int k = 0; k < 40 && !bus.door_open; k++) tick(4'b0000, 1'b0);
    checks++;
    if (!(bus.door_open && bus.floor_code == 2'd1)) begin
      errors++; $display("FAIL scan_reach_floor1 door=%b floor=%0d required door=1 floor=1", bus.door_open, bus.floor_code);
    end
    tick(4'b1001, 1'b0);
    seq.push_back(int'(bus.floor_code));
    prev_door = bus.door_open;
    for (int k = 0; k < 200; k++) begin
      tick(4'b0000, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL scan_model cyc=%0d obs=%b required=%b", k, obs_vec(), exp_vec());
      end
      if (int'(bus.floor_code) != seq[$]) seq.push_back(int'(bus.floor_code));
      if (bus.door_open && !prev_door) doors.push_back(int'(bus.floor_code));
      prev_door = bus.door_open;
    end
    checks++;
    if (seq.size() != 6) begin
      errors++; $display("FAIL scan_seq_len got=%0d required=6", seq.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (seq[i] != exp_seq[i]) begin
          errors++; $display("FAIL scan_seq[%0d] got=%0d required=%0d", i, seq[i], exp_seq[i]);
        end
      end
    end
    checks++;
    if (doors.size() != 2 || doors[0] != 3 || doors[1] != 0) begin
      errors++; $display("FAIL scan_door_floors got_count=%0d required stops 3 then 0", doors.size());
    end
    checks++;
    if (bus.pending !== 4'b0) begin
      errors++; $display("FAIL scan_pending got=%b required=0000", bus.pending);
    end
  endtask

  task automatic test_door_hold();
    int dcnt;
    do_reset();
    tick(4'b0100, 1'b0);
    for (int k = 0; k < 40 && !bus.door_open; k++) tick(4'b0000, 1'b0);
    checks++;
    if (!(bus.door_open && bus.floor_code == 2'd2)) begin
      errors++; $display("FAIL hold_reach_floor2 door=%b floor=%0d required door=1 floor=2", bus.door_open, bus.floor_code);
    end
    dcnt = 1;
    for (int k = 0; k < 10; k++) begin
      tick(4'b0100, 1'b0);
      if (bus.door_open) dcnt++;
      checks++;
      if (bus.pending[2] !== 1'b0) begin
        errors++; $display("FAIL hold_pending2 cyc=%0d got=%b required=0", k, bus.pending[2]);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL hold_model cyc=%0d obs=%b required=%b", k, obs_vec(), exp_vec());
      end
    end
    for (int k = 0; k < 20 && bus.door_open; k++) begin
      tick(4'b0000, 1'b0);
      if (bus.door_open) dcnt++;
    end
    checks++;
    if (dcnt != 10 + DT) begin
      errors++; $display("FAIL hold_door_cycles got=%0d required=%0d", dcnt, 10 + DT);
    end
  endtask

  task automatic test_reset_mid_move();
    do_reset();
    tick(4'b1000, 1'b0);
    for (int k = 0; k < 40 && bus.floor_code != 2'd2; k++) tick(4'b0000, 1'b0);
    repeat (4) tick(4'b0000, 1'b0);
    checks++;
    if ({bus.floor_code, bus.moving_up} !== 3'b101) begin
      errors++; $display("FAIL midrst_setup floor=%0d up=%b required floor=2 up=1", bus.floor_code, bus.moving_up);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs_vec() !== 9'b0) begin
      errors++; $display("FAIL midrst_immediate obs=%b required=%b", obs_vec(), 9'b0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick(4'b0000, 1'b0);
    checks++;
    if (obs_vec() !== 9'b0) begin
      errors++; $display("FAIL midrst_idle obs=%b required=%b", obs_vec(), 9'b0);
    end
    tick(4'b0010, 1'b0);
    for (int k = 1; k <= TT; k++) tick(4'b0000, 1'b0);
    checks++;
    if (obs_vec() !== {2'd1, 3'b001, 4'b0}) begin
      errors++; $display("FAIL midrst_restart obs=%b required=%b", obs_vec(), {2'd1, 3'b001, 4'b0});
    end
  endtask

`ifdef ELEV_ESTOP_EN
  task automatic test_estop();
    int fstep;
    do_reset();
    tick(4'b1000, 1'b0);
    fstep = -1;
    for (int k = 1; k <= 24; k++) begin
      tick(4'b0000, (k >= 4 && k <= 15));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL estop_model cyc=%0d obs=%b required=%b", k, obs_vec(), exp_vec());
      end
      if (k >= 4 && k <= 15) begin
        checks++;
        if ({bus.moving_up, bus.moving_down} !== 2'b00 || bus.floor_code !== 2'd0) begin
          errors++; $display("FAIL estop_frozen cyc=%0d moving=%b floor=%0d required moving=00 floor=0",
                             k, {bus.moving_up, bus.moving_down}, bus.floor_code);
        end
      end
      if (fstep < 0 && bus.floor_code == 2'd1) fstep = k;
    end
    checks++;
    if (fstep != TT + 12) begin
      errors++; $display("FAIL estop_step_time got=%0d required=%0d", fstep, TT + 12);
    end
  endtask
`endif

  task automatic test_random();
    logic [3:0] r;
    logic       e;
    do_reset();
    for (int k = 0; k < 2000; k++) begin
      r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) r = 4'b0000;
      e = 1'b0;
`ifdef ELEV_ESTOP_EN
      e = ($urandom_range(0, 15) == 0);
`endif
      tick(r, e);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL rand_model cyc=%0d req=%b obs=%b required=%b", k, r, obs_vec(), exp_vec());
      end
      checks++;
      if ((bus.moving_up && bus.moving_down) || (bus.door_open && (bus.moving_up || bus.moving_down))) begin
        errors++; $display("FAIL rand_exclusive cyc=%0d up=%b down=%b door=%b required at most one",
                           k, bus.moving_up, bus.moving_down, bus.door_open);
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    bus.req = '0;
`ifdef ELEV_ESTOP_EN
    bus.estop = 1'b0;
`endif
    model_reset();
    test_reset();
    test_single_up();
    test_scan();
    test_door_hold();
    test_reset_mid_move();
`ifdef ELEV_ESTOP_EN
    test_estop();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
